// File: rtl/fp_minmax_stream_reduce.sv
// fp_minmax_stream_reduce: streaming IEEE-754 min/max reducer.
// Accepts one float per cycle on a valid/ready stream framed by in_last and,
// at frame end, reports the extreme value, its position, the frame length and
// NaN/truncation flags. Floats are compared through an order-preserving
// unsigned key, so a single unsigned comparator handles sign, +/-0 and +/-Inf.
module fp_minmax_stream_reduce #(
  parameter  int DATA_WIDTH = 32,
  parameter  int EXP_WIDTH  = 8,
  parameter  int MAX_LEN    = 64,
  localparam int IDX_W      = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic [IDX_W:0]        out_count,
  output logic                  out_nan,
  output logic                  out_trunc
);

  localparam int MANT_W = DATA_WIDTH - 1 - EXP_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // Canonical quiet NaN: positive sign, all-ones exponent, mantissa MSB set.
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t r_state, w_state_nxt;

  // Accumulator for the frame in progress.
  logic [IDX_W:0]        r_cnt;
  logic [DATA_WIDTH-1:0] r_best_key;
  logic [DATA_WIDTH-1:0] r_best_data;
  logic [IDX_W-1:0]      r_best_idx;
  logic                  r_any_valid;
  logic                  r_nan_seen;
  logic                  r_mode;

  // Result registers presented while in HOLD.
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]      r_out_index;
  logic [IDX_W:0]        r_out_count;
  logic                  r_out_nan;
  logic                  r_out_trunc;

  logic                  w_in_xfer, w_out_xfer;
  logic                  w_is_nan;
  logic [DATA_WIDTH-1:0] w_canon, w_key;
  logic                  w_mode, w_better, w_take;
  logic [IDX_W:0]        w_cnt_nxt;
  logic                  w_hit_max, w_close;
  logic [DATA_WIDTH-1:0] w_sel_data, w_sel_key;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_valid;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // NaN: exponent all ones with a non-zero mantissa (Inf is not a NaN).
  assign w_is_nan = (&in_data[DATA_WIDTH-2 -: EXP_WIDTH]) && (|in_data[MANT_W-1:0]);

  // Order-preserving key: -0 folds onto +0 so the two compare equal; negatives
  // are inverted, non-negatives get the MSB set, then unsigned compare works.
  assign w_canon = (in_data == SIGN_BIT) ? '0 : in_data;
  assign w_key   = w_canon[DATA_WIDTH-1] ? ~w_canon : (w_canon | SIGN_BIT);

  // Mode is taken live on the first element and frozen for the rest of the frame.
  assign w_mode   = (r_cnt == '0) ? mode : r_mode;
  assign w_better = w_mode ? (w_key > r_best_key) : (w_key < r_best_key);
  // Strict compare keeps the earlier index on ties; NaNs are never selected.
  assign w_take   = !w_is_nan && (!r_any_valid || w_better);

  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_hit_max   = (w_cnt_nxt == LEN_MAX);
  assign w_close     = w_in_xfer && (in_last || w_hit_max);
  assign w_sel_data  = w_take ? in_data : r_best_data;
  assign w_sel_key   = w_take ? w_key : r_best_key;
  assign w_sel_idx   = w_take ? r_cnt[IDX_W-1:0] : r_best_idx;
  assign w_sel_valid = r_any_valid || !w_is_nan;

  // State register; reset abandons any partial frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (w_close) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (w_out_xfer) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Accumulator: update on each accepted element, clear once the result leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are a handful of flops, not a memory array, so all of them
    // get an async reset and an empty accumulator is guaranteed after reset.
    if (!rst_n) begin
      r_cnt       <= '0;
      r_best_key  <= '0;
      r_best_data <= '0;
      r_best_idx  <= '0;
      r_any_valid <= 1'b0;
      r_nan_seen  <= 1'b0;
      r_mode      <= 1'b0;
    end else if (w_out_xfer) begin
      r_cnt       <= '0;
      r_best_key  <= '0;
      r_best_data <= '0;
      r_best_idx  <= '0;
      r_any_valid <= 1'b0;
      r_nan_seen  <= 1'b0;
    end else if (w_in_xfer) begin
      r_cnt       <= w_cnt_nxt;
      r_best_key  <= w_sel_key;
      r_best_data <= w_sel_data;
      r_best_idx  <= w_sel_idx;
      r_any_valid <= w_sel_valid;
      r_nan_seen  <= r_nan_seen | w_is_nan;
      r_mode      <= w_mode;
    end
  end

  // Result capture on the closing element; held stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_count <= '0;
      r_out_nan   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else if (w_close) begin
      r_out_data  <= w_sel_valid ? w_sel_data : QNAN;
      r_out_index <= w_sel_valid ? w_sel_idx : '0;
      r_out_count <= w_cnt_nxt;
      r_out_nan   <= r_nan_seen | w_is_nan;
      r_out_trunc <= w_hit_max && !in_last;
    end
  end

  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_count = r_out_count;
  assign out_nan   = r_out_nan;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_fp_minmax_stream_reduce.sv
// Testbench for fp_minmax_stream_reduce: directed frames drive the input
// stream, expected results go into a scoreboard queue, and a monitor pops and
// compares every result the DUT hands over.
module tb_fp_minmax_stream_reduce;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic [6:0]  out_count;
  logic        out_nan;
  logic        out_trunc;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  idx;
    logic [6:0]  cnt;
    logic        nan;
    logic        trunc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] vec[64];
  int          errors = 0;
  int          checks = 0;
  int          frame_no = 0;

  fp_minmax_stream_reduce #(
    .DATA_WIDTH(32),
    .EXP_WIDTH (8),
    .MAX_LEN   (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_count(out_count),
    .out_nan  (out_nan),
    .out_trunc(out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [5:0] i, input logic [6:0] c,
                          input logic n, input logic t);
    exp_t e;
    e.data = d; e.idx = i; e.cnt = c; e.nan = n; e.trunc = t;
    sb.push_back(e);
  endtask

  // Drive vec[0..n-1]; mode is m_first on element 0 and m_rest afterwards.
  task automatic send_frame(input logic m_first, input logic m_rest, input int n,
                            input bit close_last);
    int waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = close_last && (i == n - 1);
      mode     = (i == 0) ? m_first : m_rest;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
        waited++;
        @(negedge clk);
      end
      if (!in_ready) begin
        errors++;
        checks++;
        $display("FAIL in_ready_timeout: element %0d never accepted", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      n++;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  // Monitor: a result is transferred at the next edge whenever valid and ready
  // are both high at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_result: out_data=0x%0h with empty scoreboard", out_data);
      end else begin
        e = sb.pop_front();
        check($sformatf("f%0d_out_data", frame_no),  64'(out_data),  64'(e.data));
        check($sformatf("f%0d_out_index", frame_no), 64'(out_index), 64'(e.idx));
        check($sformatf("f%0d_out_count", frame_no), 64'(out_count), 64'(e.cnt));
        check($sformatf("f%0d_out_nan", frame_no),   64'(out_nan),   64'(e.nan));
        check($sformatf("f%0d_out_trunc", frame_no), 64'(out_trunc), 64'(e.trunc));
        frame_no++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);

    // Min frame [3.0, -2.0, 1.0]; result visible right after the closing edge.
    vec[0] = 32'h4040_0000; vec[1] = 32'hC000_0000; vec[2] = 32'h3F80_0000;
    push_exp(32'hC000_0000, 6'd1, 7'd3, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 3, 1'b1);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_in_ready",  64'(in_ready),  64'd0);

    // Max frame of negatives [-1.0, -2.0, -0.5].
    vec[0] = 32'hBF80_0000; vec[1] = 32'hC000_0000; vec[2] = 32'hBF00_0000;
    push_exp(32'hBF00_0000, 6'd2, 7'd3, 1'b0, 1'b0);
    send_frame(1'b1, 1'b1, 3, 1'b1);

    // -0 and +0 tie under min: the earlier -0 wins with its sign preserved.
    vec[0] = 32'h8000_0000; vec[1] = 32'h0000_0000; vec[2] = 32'h3F80_0000;
    push_exp(32'h8000_0000, 6'd0, 7'd3, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 3, 1'b1);

    // NaN skipped under max, +Inf selected.
    vec[0] = 32'h7FC0_0001; vec[1] = 32'h4120_0000; vec[2] = 32'h7F80_0000;
    push_exp(32'h7F80_0000, 6'd2, 7'd3, 1'b1, 1'b0);
    send_frame(1'b1, 1'b1, 3, 1'b1);

    // All-NaN frame reports the canonical quiet NaN.
    vec[0] = 32'h7FC0_0000; vec[1] = 32'hFFFF_FFFF;
    push_exp(32'h7FC0_0000, 6'd0, 7'd2, 1'b1, 1'b0);
    send_frame(1'b0, 1'b0, 2, 1'b1);
    wait_drain();

    // Backpressure: result held with in_ready low for 5 cycles.
    out_ready = 1'b0;
    vec[0] = 32'h4000_0000; vec[1] = 32'h4080_0000;
    push_exp(32'h4080_0000, 6'd1, 7'd2, 1'b0, 1'b0);
    send_frame(1'b1, 1'b1, 2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", c),  64'(in_ready),  64'd0);
      check($sformatf("bp%0d_out_data", c),  64'(out_data),  64'h4080_0000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // 64 elements without last: force-closed, truncated, max at index 40.
    for (int i = 0; i < 64; i++) vec[i] = 32'h3F80_0000 + (32'(i) << 16);
    vec[40] = 32'h42C8_0000;
    push_exp(32'h42C8_0000, 6'd40, 7'd64, 1'b0, 1'b1);
    send_frame(1'b1, 1'b1, 64, 1'b0);

    // Next frame starts clean.
    vec[0] = 32'h4000_0000;
    push_exp(32'h4000_0000, 6'd0, 7'd1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1, 1'b1);

    // 64 elements with last on the final one: not truncated, min at index 63.
    for (int i = 0; i < 63; i++) vec[i] = 32'h3F80_0000;
    vec[63] = 32'hBF80_0000;
    push_exp(32'hBF80_0000, 6'd63, 7'd64, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 64, 1'b1);

    // Mode flips to max after the first element; the frame stays a min frame.
    vec[0] = 32'h4000_0000; vec[1] = 32'h3F80_0000; vec[2] = 32'h4040_0000;
    push_exp(32'h3F80_0000, 6'd1, 7'd3, 1'b0, 1'b0);
    send_frame(1'b0, 1'b1, 3, 1'b1);
    wait_drain();

    // Reset after two accepted elements discards the frame and clears outputs.
    vec[0] = 32'h40A0_0000; vec[1] = 32'h40C0_0000;
    send_frame(1'b0, 1'b0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data",  64'(out_data),  64'd0);
    check("mid_rst_out_index", 64'(out_index), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    check("mid_rst_out_nan",   64'(out_nan),   64'd0);
    check("mid_rst_out_trunc", 64'(out_trunc), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    vec[0] = 32'h3F80_0000;
    push_exp(32'h3F80_0000, 6'd0, 7'd1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
